// File: rtl/fifo_pkg.sv
// Shared state encoding and fifo timing constants for the fifo read-side controller.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10
  } state_e;

  // Cycles between fifo_rd_en_o and the matching word on fifo_dout_i.
  localparam int FIFO_RD_LAT = 1;

endpackage

// File: rtl/fifo_reader_if.sv
// Fifo read port plus downstream stream, bundled for the reader (master) and its peers (slave).
interface fifo_reader_if #(
  parameter int WIDTH = 8
);

  logic             fifo_rd_en_o;
  logic             fifo_empty_i;
  logic [WIDTH-1:0] fifo_dout_i;
  logic             m_valid_o;
  logic [WIDTH-1:0] m_data_o;
  logic             m_ready_i;

  // Stream: a word moves on every edge where m_valid_o && m_ready_i; once raised,
  // m_valid_o and m_data_o hold until accepted, unless a flush discards the word.
  modport master (
    output fifo_rd_en_o, m_valid_o, m_data_o,
    input  fifo_empty_i, fifo_dout_i, m_ready_i
  );

  modport slave (
    input  fifo_rd_en_o, m_valid_o, m_data_o,
    output fifo_empty_i, fifo_dout_i, m_ready_i
  );

endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order buffer absorbing the fifo read latency; head is the registered output word.
module fifo_reader_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] tail;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (clear) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= din;
          else             tail <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          // Head keeps its last value when the buffer empties.
          if (occ == 2'd2) head <= tail;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head <= tail;
            tail <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Fifo read-side controller: pops the fifo, streams words out through a skid buffer,
// and can flush (drain and discard) the fifo while counting delivered and dropped words.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             enable_i,
  input  logic             flush_i,
  fifo_reader_if.master    bus,
  output logic             busy_o,
  output logic [CNT_W-1:0] deliv_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic [1:0]       state_o
);

  state_e                 state;
  logic [FIFO_RD_LAT-1:0] inflight;
  logic [1:0]             occ;
  logic [WIDTH-1:0]       head;
  logic                   accept;
  logic                   enter_flush;
  logic                   push;
  logic                   rd_en;
  logic [2:0]             pending;
  logic [CNT_W-1:0]       drop_inc;

  assign accept      = bus.m_valid_o && bus.m_ready_i;
  assign enter_flush = flush_i && (state != FLUSH);
  assign push        = inflight[0] && (state != FLUSH) && !enter_flush;
  assign pending     = {1'b0, occ} + {2'b00, inflight[0]};

  // A full buffer may still issue a read when its head leaves this cycle; that keeps
  // the stream at one word per cycle without ever overfilling the two entries.
  always_comb begin
    rd_en = 1'b0;
    case (state)
      RUN:     rd_en = enable_i && !bus.fifo_empty_i && ((pending < 3'd2) || accept);
      FLUSH:   rd_en = !bus.fifo_empty_i;
      default: rd_en = 1'b0;
    endcase
  end

  always_comb begin
    drop_inc = '0;
    if (enter_flush)
      drop_inc = CNT_W'(occ) - CNT_W'(accept) + CNT_W'(inflight[0]);
    else if ((state == FLUSH) && inflight[0])
      drop_inc = CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      inflight    <= '0;
      deliv_cnt_o <= '0;
      drop_cnt_o  <= '0;
    end else begin
      inflight   <= rd_en;
      drop_cnt_o <= drop_cnt_o + drop_inc;
      if (accept) deliv_cnt_o <= deliv_cnt_o + CNT_W'(1);
      case (state)
        IDLE: begin
          if (flush_i)       state <= FLUSH;
          else if (enable_i) state <= RUN;
        end
        RUN: begin
          if (flush_i)                         state <= FLUSH;
          else if (!enable_i && !inflight[0])  state <= IDLE;
        end
        FLUSH: begin
          if (bus.fifo_empty_i && !inflight[0]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fifo_reader_skid #(.WIDTH(WIDTH)) u_skid (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clear    (enter_flush),
    .push     (push),
    .pop      (accept),
    .din      (bus.fifo_dout_i),
    .occ      (occ),
    .head     (head)
  );

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.m_valid_o    = (occ != 2'd0) && (state != FLUSH);
  assign bus.m_data_o     = head;
  assign busy_o           = (state == FLUSH) || (occ != 2'd0) || inflight[0];
  assign state_o          = state;

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: behavioural fifo with registered read, stream scoreboard, scenario tasks.
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int W     = 8;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << 17;

  // ---------------- clock / reset ----------------
  logic clk_i    = 1'b0;
  logic reset_ni = 1'b0;
  logic enable_i = 1'b0;
  logic flush_i  = 1'b0;
  logic m_ready  = 1'b0;

  logic          busy_o;
  logic [CW-1:0] deliv_cnt_o;
  logic [CW-1:0] drop_cnt_o;
  logic [1:0]    state_o;

  always #5 clk_i = ~clk_i;

  fifo_reader_if #(.WIDTH(W)) bus();

  fifo_reader #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .enable_i    (enable_i),
    .flush_i     (flush_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .deliv_cnt_o (deliv_cnt_o),
    .drop_cnt_o  (drop_cnt_o),
    .state_o     (state_o)
  );

  // ---------------- fifo model (registered read, registered empty) ----------------
  logic [W-1:0] fifo_mem [DEPTH];
  int           fifo_wr     = 0;
  int           fifo_rd     = 0;
  int           empty_reads = 0;
  logic         fifo_empty  = 1'b1;
  logic [W-1:0] fifo_dout   = '0;

  assign bus.fifo_empty_i = fifo_empty;
  assign bus.fifo_dout_i  = fifo_dout;
  assign bus.m_ready_i    = m_ready;

  always @(posedge clk_i) begin
    if (bus.fifo_rd_en_o) begin
      if (fifo_empty || (fifo_rd == fifo_wr)) begin
        empty_reads++;
      end else begin
        fifo_dout <= fifo_mem[fifo_rd];
        fifo_rd++;
      end
    end
    fifo_empty <= (fifo_rd == fifo_wr);
  end

  // ---------------- stream monitor ----------------
  logic [W-1:0] obs_mem [DEPTH];
  int           obs_wr = 0;
  int           rd_cnt = 0;

  always @(negedge clk_i) begin
    if (bus.fifo_rd_en_o) rd_cnt++;
    if (reset_ni && bus.m_valid_o && m_ready) begin
      obs_mem[obs_wr] = bus.m_data_o;
      obs_wr++;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           obs_rd   = 0;
  int           n_checks = 0;
  int           n_fail   = 0;

  // ---------------- driver tasks ----------------
  task automatic load_word(input logic [W-1:0] d, input bit expect_out);
    fifo_mem[fifo_wr] = d;
    fifo_wr++;
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (!busy_o && fifo_empty && (fifo_rd == fifo_wr)) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic wait_state_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (state_o == IDLE) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if ({bus.m_valid_o, bus.fifo_rd_en_o, busy_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: valid/rd_en/busy=%b required 000", {bus.m_valid_o, bus.fifo_rd_en_o, busy_o});
    end
    n_checks++;
    if ((deliv_cnt_o !== '0) || (drop_cnt_o !== '0)) begin
      n_fail++;
      $display("FAIL reset_cnt: deliv=%0d drop=%0d required 0 0", deliv_cnt_o, drop_cnt_o);
    end
    n_checks++;
    if ((bus.m_data_o !== '0) || (state_o !== IDLE)) begin
      n_fail++;
      $display("FAIL reset_data_state: data=%h state=%0d required 00 0", bus.m_data_o, state_o);
    end
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
  endtask

  task automatic test_stream();
    logic [3:0]    rd_bits;
    int            first_v;
    int            r0;
    logic [CW-1:0] d0;
    bit            ok;
    logic [W-1:0]  e;
    @(posedge clk_i); #1;
    enable_i = 1'b1;
    m_ready  = 1'b1;
    @(posedge clk_i); #1;
    r0 = rd_cnt;
    d0 = deliv_cnt_o;
    for (int i = 0; i < 4; i++) load_word(W'(8'hA1 + i), 1'b1);
    for (int g = 0; g < 10; g++) begin
      @(negedge clk_i);
      if (!fifo_empty) break;
    end
    rd_bits = '0;
    first_v = -1;
    for (int i = 0; i < 4; i++) begin
      rd_bits[i] = bus.fifo_rd_en_o;
      if (bus.m_valid_o && (first_v < 0)) first_v = i;
      @(negedge clk_i);
    end
    n_checks++;
    if (rd_bits !== 4'b1111) begin
      n_fail++;
      $display("FAIL stream_rd_pattern: rd_en over 4 cycles=%b required 1111", rd_bits);
    end
    n_checks++;
    if (first_v != 2) begin
      n_fail++;
      $display("FAIL stream_latency: first valid %0d cycles after empty fell, required 2", first_v);
    end
    wait_idle(50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stream_timeout: did not go idle, got busy=%b required 0", busy_o);
    end
    n_checks++;
    if ((rd_cnt - r0 != 4) || (deliv_cnt_o - d0 !== 16'd4)) begin
      n_fail++;
      $display("FAIL stream_counts: reads=%0d deliv=%0d required 4 4", rd_cnt - r0, deliv_cnt_o - d0);
    end
    while (obs_rd < obs_wr) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream_data: got %h with no word expected", obs_mem[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[obs_rd] !== e) begin
          n_fail++;
          $display("FAIL stream_data: got %h required %h", obs_mem[obs_rd], e);
        end
      end
      obs_rd++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_missing: %0d words not delivered, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_stall();
    int           r0;
    bit           stable;
    bit           ok;
    logic [W-1:0] e;
    @(posedge clk_i); #1;
    m_ready = 1'b0;
    r0 = rd_cnt;
    for (int i = 0; i < 4; i++) load_word(W'($urandom_range(0, 255)), 1'b1);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk_i);
      if (bus.m_valid_o && (bus.m_data_o !== exp_q[0])) stable = 1'b0;
    end
    n_checks++;
    if (rd_cnt - r0 != 2) begin
      n_fail++;
      $display("FAIL stall_reads: reads=%0d required 2", rd_cnt - r0);
    end
    n_checks++;
    if (!stable || !bus.m_valid_o || (bus.m_data_o !== exp_q[0])) begin
      n_fail++;
      $display("FAIL stall_hold: valid=%b data=%h required 1 %h", bus.m_valid_o, bus.m_data_o, exp_q[0]);
    end
    @(posedge clk_i); #1;
    m_ready = 1'b1;
    wait_idle(50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_timeout: did not go idle, got busy=%b required 0", busy_o);
    end
    while (obs_rd < obs_wr) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stall_data: got %h with no word expected", obs_mem[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[obs_rd] !== e) begin
          n_fail++;
          $display("FAIL stall_data: got %h required %h", obs_mem[obs_rd], e);
        end
      end
      obs_rd++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_missing: %0d words not delivered, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_empty();
    int           e0;
    int           r0;
    bit           got;
    logic [W-1:0] e;
    @(posedge clk_i); #1;
    m_ready = 1'b1;
    e0 = empty_reads;
    r0 = rd_cnt;
    load_word(W'($urandom_range(0, 255)), 1'b1);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (bus.m_valid_o) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got || !busy_o) begin
      n_fail++;
      $display("FAIL empty_accept: valid=%b busy=%b required 1 1", bus.m_valid_o, busy_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_busy_fall: busy=%b one cycle after accept, required 0", busy_o);
    end
    repeat (5) @(negedge clk_i);
    n_checks++;
    if ((empty_reads != e0) || (rd_cnt - r0 != 1)) begin
      n_fail++;
      $display("FAIL empty_no_read: empty reads=%0d reads=%0d required 0 1", empty_reads - e0, rd_cnt - r0);
    end
    while (obs_rd < obs_wr) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL empty_data: got %h with no word expected", obs_mem[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[obs_rd] !== e) begin
          n_fail++;
          $display("FAIL empty_data: got %h required %h", obs_mem[obs_rd], e);
        end
      end
      obs_rd++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL empty_missing: %0d words not delivered, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_flush();
    logic [CW-1:0] d0;
    logic [CW-1:0] p0;
    bit            ok;
    @(posedge clk_i); #1;
    m_ready = 1'b0;
    d0 = deliv_cnt_o;
    p0 = drop_cnt_o;
    for (int i = 0; i < 6; i++) load_word(W'($urandom_range(0, 255)), 1'b0);
    repeat (6) @(negedge clk_i);
    @(posedge clk_i); #1;
    flush_i  = 1'b1;
    enable_i = 1'b0;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    n_checks++;
    if (bus.m_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_valid_drop: valid=%b right after flush, required 0", bus.m_valid_o);
    end
    wait_state_idle(40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL flush_timeout: state=%0d required IDLE", state_o);
    end
    n_checks++;
    if ((drop_cnt_o - p0 !== 16'd6) || (deliv_cnt_o - d0 !== 16'd0)) begin
      n_fail++;
      $display("FAIL flush_counts: dropped=%0d delivered=%0d required 6 0", drop_cnt_o - p0, deliv_cnt_o - d0);
    end
    n_checks++;
    if ((fifo_rd != fifo_wr) || busy_o || (obs_wr != obs_rd)) begin
      n_fail++;
      $display("FAIL flush_drained: fifo left=%0d busy=%b stray outputs=%0d required 0 0 0",
               fifo_wr - fifo_rd, busy_o, obs_wr - obs_rd);
    end
  endtask

  task automatic test_reset_midburst();
    bit seen;
    bit clean;
    bit ok;
    @(posedge clk_i); #1;
    m_ready  = 1'b0;
    enable_i = 1'b1;
    for (int i = 0; i < 4; i++) load_word(W'($urandom_range(0, 255)), 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (bus.fifo_rd_en_o) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midreset_issue: rd_en=%b never seen, required 1", bus.fifo_rd_en_o);
    end
    @(posedge clk_i); #1;
    reset_ni = 1'b0;
    #1;
    n_checks++;
    if ({bus.m_valid_o, bus.fifo_rd_en_o, busy_o} !== 3'b000 || (bus.m_data_o !== '0)) begin
      n_fail++;
      $display("FAIL midreset_async: valid/rd_en/busy=%b data=%h required 000 00",
               {bus.m_valid_o, bus.fifo_rd_en_o, busy_o}, bus.m_data_o);
    end
    n_checks++;
    if ((deliv_cnt_o !== '0) || (drop_cnt_o !== '0) || (state_o !== IDLE)) begin
      n_fail++;
      $display("FAIL midreset_regs: deliv=%0d drop=%0d state=%0d required 0 0 0", deliv_cnt_o, drop_cnt_o, state_o);
    end
    enable_i = 1'b0;
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    clean = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      if (bus.m_valid_o || busy_o || bus.fifo_rd_en_o) clean = 1'b0;
    end
    n_checks++;
    if (!clean || (fifo_wr - fifo_rd != 3)) begin
      n_fail++;
      $display("FAIL midreset_release: clean=%b fifo left=%0d required 1 3", clean, fifo_wr - fifo_rd);
    end
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    wait_state_idle(40, ok);
    n_checks++;
    if (!ok || (drop_cnt_o !== 16'd3) || (deliv_cnt_o !== 16'd0)) begin
      n_fail++;
      $display("FAIL midreset_flush: idle=%b drop=%0d deliv=%0d required 1 3 0", ok, drop_cnt_o, deliv_cnt_o);
    end
  endtask

  task automatic test_wrap();
    bit           ok;
    int           bad;
    int           n_obs;
    logic [W-1:0] e;
    @(posedge clk_i); #1;
    reset_ni = 1'b0;
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    enable_i = 1'b1;
    m_ready  = 1'b1;
    @(posedge clk_i); #1;
    for (int i = 0; i < 65535; i++) load_word(W'($urandom_range(0, 255)), 1'b1);
    wait_idle(70000, ok);
    n_checks++;
    if (!ok || (deliv_cnt_o !== 16'hFFFF)) begin
      n_fail++;
      $display("FAIL wrap_preload: idle=%b deliv=%h required 1 ffff", ok, deliv_cnt_o);
    end
    @(posedge clk_i); #1;
    load_word(W'($urandom_range(0, 255)), 1'b1);
    wait_idle(20, ok);
    n_checks++;
    if (!ok || (deliv_cnt_o !== 16'h0000) || (drop_cnt_o !== 16'h0000)) begin
      n_fail++;
      $display("FAIL wrap_rollover: idle=%b deliv=%h drop=%h required 1 0000 0000", ok, deliv_cnt_o, drop_cnt_o);
    end
    bad   = 0;
    n_obs = 0;
    while (obs_rd < obs_wr) begin
      if (exp_q.size() == 0) begin
        bad++;
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[obs_rd] !== e) bad++;
      end
      n_obs++;
      obs_rd++;
    end
    n_checks++;
    if ((bad != 0) || (n_obs != 65536) || (exp_q.size() != 0)) begin
      n_fail++;
      $display("FAIL wrap_data: wrong=%0d seen=%0d missing=%0d required 0 65536 0", bad, n_obs, exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_empty();
    test_flush();
    test_reset_midburst();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
